reverb_st_to_mm_fifo: RTL
=========================

// Module: reverb_st_to_mm_fifo
// PURPOSE
//  Parametrised Avalon-ST sink -> Avalon-MM read-slave FIFO: successor to the fixed 32x32 s2m FIFO.
//  Buffers filter output samples (FIR/reverb path) for CPU pop over Avalon-MM.
//  Adds configurable width/depth, a status/level register, an almost-full IRQ,
//  selectable blocking/non-blocking pop, and a software flush.
// PARAMETERS
//  DATA_WIDTH    32  sample width, bits (8..32)
//  ADDR_WIDTH    5   log2(depth); DEPTH = 2**ADDR_WIDTH words
//  ALMOST_FULL   24  level at or above which irq asserts (1..DEPTH)
//  BLOCKING_READ 1   1: pop of empty FIFO stalls via waitrequest; 0: returns 0, sets underflow
// PORTS
//  wrclock                          in   1            single clock, all logic on rising edge
//  reset                            in   1            synchronous, active-high
//  avalonst_sink_data               in   DATA_WIDTH   sample in
//  avalonst_sink_valid              in   1            sample valid
//  avalonst_sink_ready              out  1            = !full (ready latency 0)
//  avalonmm_read_slave_address      in   2            0 DATA, 1 STATUS, 2 CONTROL
//  avalonmm_read_slave_read         in   1            read strobe
//  avalonmm_read_slave_write        in   1            write strobe (CONTROL only)
//  avalonmm_read_slave_writedata    in   32           control word
//  avalonmm_read_slave_readdata     out  32           read data, valid when waitrequest low
//  avalonmm_read_slave_waitrequest  out  1            stall
//  irq                              out  1            level >= ALMOST_FULL
// BEHAVIOUR
//  Reset: count=0, rd/wr pointers=0, underflow=0; ready=0, waitrequest=0, irq=0, readdata=0.
//  Push: valid&ready -> mem[wr_ptr]<=data, wr_ptr++ (mod DEPTH). Full push refused (ready=0) even if pop same cycle.
//  DATA read (addr 0), non-empty: waitrequest=0, readdata=zero-ext mem[rd_ptr] combinationally, rd_ptr++ at edge.
//  DATA read, empty: BLOCKING_READ=1 -> waitrequest=1 until count>0; sample pushed in cycle N poppable in N+1.
//    BLOCKING_READ=0 -> waitrequest=0, readdata=0, underflow<=1, no pointer change.
//  Simultaneous push+pop: count unchanged, both pointers advance.
//  count width ADDR_WIDTH+1; full = count==DEPTH; empty = count==0; pointers wrap naturally.
//  STATUS read (addr 1), 1 cycle, no side effect: [31]=underflow, [30]=full, [29]=empty,
//    [ADDR_WIDTH:0]=count, rest 0.
//  CONTROL write (addr 2): bit0=1 clears underflow; bit1=1 flush (pointers, count <=0).
//    Flush + push same cycle: flush applies, pushed word stored at mem[0], count=1.
//    Flush + DATA pop same cycle: pop returns current head, then flush (pop discarded).
//    Underflow set + clear same cycle: set wins.
//  Read of addr 2/3 returns 0; write to addr 0/1 ignored. read&write together: read only.
//  irq registered: irq <= (next count >= ALMOST_FULL); 1-cycle lag vs count.
//  Reset mid-transfer: stored data lost, in-flight beat dropped, waitrequest drops next cycle.
// STRUCTURE
//  Package reverb_fifo_pkg: register address localparams (ADDR_DATA/STATUS/CONTROL),
//    STATUS bit positions, CONTROL bit positions.
//  Sub-module reverb_st_to_mm_fifo_ram: DATA_WIDTH x DEPTH register array, 1 write port,
//    async read port (no RAM output register). Top holds pointers, count, Avalon decode.
// TESTING
//  Reset, push 3 words 0xA1,0xA2,0xA3, pop 3x -> same order, STATUS count 3 then 0, empty=1.
//  Fill DEPTH=32 words -> ready=0 on 32nd accept+1, full=1, irq=1 once count>=24; extra valid ignored.
//  Pop at count=32 while valid=1 -> word popped, push refused that cycle; next cycle push accepted.
//  BLOCKING_READ=1: pop empty, push 0x55 two cycles later -> waitrequest high 3 cycles, readdata 0x55.
//  BLOCKING_READ=0: pop empty -> readdata 0, STATUS[31]=1; write CONTROL=1 -> STATUS[31]=0.
//  Count=10, write CONTROL=2 with concurrent push 0x77 -> count=1, next pop returns 0x77; wrap after 40 pushes/pops holds order.

Source files
------------

// File: rtl/reverb_fifo_pkg.sv
// reverb_fifo_pkg: register map shared by the ST-to-MM sample FIFO
package reverb_fifo_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam int ST_UNDERFLOW = 31;
  localparam int ST_FULL = 30;
  localparam int ST_EMPTY = 29;
  localparam int CTL_CLR_UNDERFLOW = 0;
  localparam int CTL_FLUSH = 1;
endpackage

// File: rtl/reverb_st_to_mm_fifo_ram.sv
// reverb_st_to_mm_fifo_ram: register-array storage, one write port, asynchronous read port
module reverb_st_to_mm_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  assign rdata = mem[raddr];
  // store one sample per accepted beat; contents are not cleared by reset
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/reverb_st_to_mm_fifo.sv
// reverb_st_to_mm_fifo: Avalon-ST sink to Avalon-MM read-slave sample FIFO with status, irq and flush
module reverb_st_to_mm_fifo
  import reverb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ALMOST_FULL = 24,
  parameter int BLOCKING_READ = 1
) (
  input  logic                  wrclock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] avalonst_sink_data,
  input  logic                  avalonst_sink_valid,
  output logic                  avalonst_sink_ready,
  input  logic [1:0]            avalonmm_read_slave_address,
  input  logic                  avalonmm_read_slave_read,
  input  logic                  avalonmm_read_slave_write,
  input  logic [31:0]           avalonmm_read_slave_writedata,
  output logic [31:0]           avalonmm_read_slave_readdata,
  output logic                  avalonmm_read_slave_waitrequest,
  output logic                  irq
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF = CW'(ALMOST_FULL);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] count, count_next;
  logic [DATA_WIDTH-1:0] head;
  logic [31:0] status;
  logic underflow, full, empty, rd, wr, push, pop, flush, clr, under_set, data_rd, unused_wd;
  assign full = count[ADDR_WIDTH];
  assign empty = count == '0;
  assign rd = avalonmm_read_slave_read;
  assign wr = avalonmm_read_slave_write && !rd;
  assign data_rd = rd && avalonmm_read_slave_address == ADDR_DATA;
  assign avalonst_sink_ready = !full && !reset;
  assign push = avalonst_sink_valid && avalonst_sink_ready;
  assign pop = data_rd && !empty;
  assign under_set = data_rd && empty && BLOCKING_READ == 0;
  assign flush = wr && avalonmm_read_slave_address == ADDR_CONTROL && avalonmm_read_slave_writedata[CTL_FLUSH];
  assign clr = wr && avalonmm_read_slave_address == ADDR_CONTROL && avalonmm_read_slave_writedata[CTL_CLR_UNDERFLOW];
  assign unused_wd = ^avalonmm_read_slave_writedata[31:2];
  assign avalonmm_read_slave_waitrequest = !reset && data_rd && empty && BLOCKING_READ != 0;
  // a flush discards everything except a word pushed in the same cycle
  assign count_next = flush ? CW'(push) : count + CW'(push) - CW'(pop);
  // status word: sticky underflow, full, empty flags over the live level
  always_comb begin
    status = 32'(count);
    status[ST_UNDERFLOW] = underflow;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
  end
  assign avalonmm_read_slave_readdata = (reset || !rd) ? '0 :
    avalonmm_read_slave_address == ADDR_DATA ? (empty ? '0 : 32'(head)) :
    avalonmm_read_slave_address == ADDR_STATUS ? status : '0;
  reverb_st_to_mm_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock(wrclock),
    .we(push),
    .waddr(flush ? '0 : wr_ptr),
    .wdata(avalonst_sink_data),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // pointers, level, sticky underflow (set beats clear) and registered almost-full irq
  always_ff @(posedge wrclock)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      underflow <= 1'b0;
      irq <= 1'b0;
    end else begin
      wr_ptr <= flush ? ADDR_WIDTH'(push) : wr_ptr + ADDR_WIDTH'(push);
      rd_ptr <= flush ? '0 : rd_ptr + ADDR_WIDTH'(pop);
      count <= count_next;
      underflow <= under_set || (underflow && !clr);
      irq <= count_next >= AF;
    end
endmodule
